// File: rtl/image_pattern_source.sv
// Synthetic test-pattern frame source for the valid/ready/request/cancel image bus.
// Emits one Width x Height frame per sampled request, one pixel per clock under full throughput.
module image_pattern_source #(
  parameter int Dw      = 8,
  parameter int Width   = 8,
  parameter int Height  = 4,
  parameter int Pattern = 0
) (
  input  logic          clock,
  input  logic          reset,
  output logic          image_out_valid,
  input  logic          image_out_ready,
  input  logic          image_out_request,
  input  logic          image_out_cancel,
  output logic          image_out_start,
  output logic          image_out_stop,
  output logic [Dw-1:0] image_out_data,
  output logic          image_out_error
);

  localparam int XW = (Width > 1) ? $clog2(Width) : 1;
  localparam int YW = (Height > 1) ? $clog2(Height) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(Width - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Height - 1);
  localparam logic [XW-1:0] X_ZERO = XW'(0);
  localparam logic [YW-1:0] Y_ZERO = YW'(0);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);
  localparam logic [Dw-1:0] F_ONE  = Dw'(1);
  localparam logic [1:0]    PAT    = 2'(Pattern);
  localparam logic ONE_PIXEL = ((Width == 1) && (Height == 1)) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  // Pixel value for coordinate (px, py) of frame fr, truncated to the bus width.
  function automatic logic [Dw-1:0] pixel_f(
    input logic [XW-1:0] px,
    input logic [YW-1:0] py,
    input logic [Dw-1:0] fr
  );
    logic [Dw-1:0] v;
    case (PAT)
      2'd0:    v = Dw'(px);
      2'd1:    v = Dw'(py);
      2'd2:    v = Dw'(px) + Dw'(py) + fr;
      2'd3:    v = (px[0] ^ py[0]) ? {Dw{1'b1}} : {Dw{1'b0}};
      default: v = {Dw{1'b0}};
    endcase
    return v;
  endfunction

  state_t        state_r, state_s;
  logic [XW-1:0] x_r, x_s, step_x_s;
  logic [YW-1:0] y_r, y_s, step_y_s;
  logic [Dw-1:0] frame_r, frame_s;
  logic          valid_r, valid_s;
  logic          start_r, start_s;
  logic          stop_r, stop_s;
  logic [Dw-1:0] data_r, data_s;
  logic          error_r;
  logic          last_s;
  logic          xfer_s;

  // Raster-order successor of the current pixel and last-pixel detection.
  always_comb begin
    step_x_s = x_r;
    step_y_s = y_r;
    if (x_r == X_LAST) begin
      step_x_s = X_ZERO;
      step_y_s = y_r + Y_ONE;
    end else begin
      step_x_s = x_r + X_ONE;
      step_y_s = y_r;
    end
    last_s = (x_r == X_LAST) && (y_r == Y_LAST);
    xfer_s = valid_r & image_out_ready;
  end

  // Next-state and next-bus computation; cancel overrides every state.
  always_comb begin
    state_s = state_r;
    x_s     = x_r;
    y_s     = y_r;
    frame_s = frame_r;
    valid_s = valid_r;
    start_s = start_r;
    stop_s  = stop_r;
    data_s  = data_r;
    if (image_out_cancel) begin
      state_s = ST_IDLE;
      x_s     = X_ZERO;
      y_s     = Y_ZERO;
      valid_s = 1'b0;
      start_s = 1'b0;
      stop_s  = 1'b0;
      data_s  = {Dw{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          valid_s = 1'b0;
          if (image_out_request) begin
            state_s = ST_STREAM;
            x_s     = X_ZERO;
            y_s     = Y_ZERO;
            valid_s = 1'b1;
            start_s = 1'b1;
            stop_s  = ONE_PIXEL;
            data_s  = pixel_f(X_ZERO, Y_ZERO, frame_r);
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_STREAM: begin
          if (xfer_s && last_s) begin
            state_s = ST_GAP;
            x_s     = X_ZERO;
            y_s     = Y_ZERO;
            frame_s = frame_r + F_ONE;
            valid_s = 1'b0;
            start_s = 1'b0;
            stop_s  = 1'b0;
            data_s  = {Dw{1'b0}};
          end else if (xfer_s) begin
            x_s     = step_x_s;
            y_s     = step_y_s;
            start_s = 1'b0;
            stop_s  = (step_x_s == X_LAST) && (step_y_s == Y_LAST);
            data_s  = pixel_f(step_x_s, step_y_s, frame_r);
          end else begin
            state_s = ST_STREAM;
          end
        end
        ST_GAP: begin
          state_s = ST_IDLE;
          valid_s = 1'b0;
        end
        default: begin
          state_s = ST_IDLE;
          x_s     = X_ZERO;
          y_s     = Y_ZERO;
          valid_s = 1'b0;
          start_s = 1'b0;
          stop_s  = 1'b0;
          data_s  = {Dw{1'b0}};
        end
      endcase
    end
  end

  // State, counters and registered bus outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      x_r     <= X_ZERO;
      y_r     <= Y_ZERO;
      frame_r <= {Dw{1'b0}};
      valid_r <= 1'b0;
      start_r <= 1'b0;
      stop_r  <= 1'b0;
      data_r  <= {Dw{1'b0}};
      error_r <= 1'b0;
    end else begin
      state_r <= state_s;
      x_r     <= x_s;
      y_r     <= y_s;
      frame_r <= frame_s;
      valid_r <= valid_s;
      start_r <= start_s;
      stop_r  <= stop_s;
      data_r  <= data_s;
      error_r <= 1'b0;
    end
  end

  assign image_out_valid = valid_r;
  assign image_out_start = start_r;
  assign image_out_stop  = stop_r;
  assign image_out_data  = data_r;
  assign image_out_error = error_r;

endmodule

// File: tb/tb_image_pattern_source.sv
// Bench for image_pattern_source: several configurations driven by shared stimulus,
// checked every cycle against a pixel-index/frame-count model plus hand-computed sequences.
module tb_image_pattern_source;

  localparam int NI = 7;
  localparam int CW [NI] = '{4, 2, 2, 4, 1, 3, 5};
  localparam int CH [NI] = '{2, 2, 2, 2, 1, 3, 3};
  localparam int CP [NI] = '{0, 2, 2, 2, 2, 3, 1};
  localparam int CD [NI] = '{8, 8, 2, 8, 8, 4, 8};

  localparam int EXP_P2_D8 [12] = '{0, 1, 1, 2, 1, 2, 2, 3, 2, 3, 3, 4};
  localparam int EXP_P2_D2 [12] = '{0, 1, 1, 2, 1, 2, 2, 3, 2, 3, 3, 0};
  localparam int EXP_RAMP  [8]  = '{0, 1, 2, 3, 0, 1, 2, 3};

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ready = 1'b0;
  logic request = 1'b0;
  logic cancel = 1'b0;

  logic [NI-1:0] o_valid, o_start, o_stop, o_error;
  logic [7:0]    o_data [NI];

  int n_chk = 0;
  int n_err = 0;

  // model state: streaming flag, raster pixel index, frames completed, gap cycle pending
  int m_act [NI];
  int m_idx [NI];
  int m_frame [NI];
  int m_gap [NI];

  // transfer log since the last reset
  int lg_data [NI][64];
  int lg_n [NI];

  always #5 clock = ~clock;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [CD[g]-1:0] data_w;
    logic valid_w, start_w, stop_w, error_w;
    image_pattern_source #(
      .Dw(CD[g]), .Width(CW[g]), .Height(CH[g]), .Pattern(CP[g])
    ) u_dut (
      .clock(clock),
      .reset(reset),
      .image_out_valid(valid_w),
      .image_out_ready(ready),
      .image_out_request(request),
      .image_out_cancel(cancel),
      .image_out_start(start_w),
      .image_out_stop(stop_w),
      .image_out_data(data_w),
      .image_out_error(error_w)
    );
    assign o_valid[g] = valid_w;
    assign o_start[g] = start_w;
    assign o_stop[g]  = stop_w;
    assign o_error[g] = error_w;
    assign o_data[g]  = 8'(data_w);
  end

  task automatic chk(input string name, input int g, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s [inst %0d] t=%0t: got %0d, expected %0d", name, g, $time, act, exp);
    end
  endtask

  function automatic int exp_data(input int g);
    int x, y, v;
    x = m_idx[g] % CW[g];
    y = m_idx[g] / CW[g];
    case (CP[g])
      0: v = x;
      1: v = y;
      2: v = x + y + m_frame[g];
      default: v = (((x ^ y) & 1) != 0) ? 255 : 0;
    endcase
    return v & ((1 << CD[g]) - 1);
  endfunction

  // Reference model: advances on each rising edge from the sampled consumer inputs.
  initial begin
    forever begin
      @(posedge clock or posedge reset);
      for (int g = 0; g < NI; g++) begin
        if (reset) begin
          m_act[g] = 0; m_idx[g] = 0; m_frame[g] = 0; m_gap[g] = 0;
        end else if (cancel) begin
          m_act[g] = 0; m_idx[g] = 0; m_gap[g] = 0;
        end else if (m_act[g] != 0) begin
          if (ready) begin
            if (m_idx[g] == CW[g] * CH[g] - 1) begin
              m_act[g] = 0; m_idx[g] = 0; m_frame[g]++; m_gap[g] = 1;
            end else begin
              m_idx[g]++;
            end
          end
        end else if (m_gap[g] != 0) begin
          m_gap[g] = 0;
        end else if (request) begin
          m_act[g] = 1;
        end
      end
    end
  end

  // Compare process: every falling edge, all instances against the model; logs transfers.
  initial begin
    forever begin
      @(negedge clock);
      for (int g = 0; g < NI; g++) begin
        chk("error", g, int'(o_error[g]), 0);
        chk("valid", g, int'(o_valid[g]), m_act[g]);
        if (m_act[g] != 0) begin
          chk("data", g, int'(o_data[g]), exp_data(g));
          chk("start", g, int'(o_start[g]), (m_idx[g] == 0) ? 1 : 0);
          chk("stop", g, int'(o_stop[g]), (m_idx[g] == CW[g] * CH[g] - 1) ? 1 : 0);
        end
        if (reset) begin
          lg_n[g] = 0;
        end else if (o_valid[g] && ready && !cancel && lg_n[g] < 64) begin
          lg_data[g][lg_n[g]] = int'(o_data[g]);
          lg_n[g]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_valid(input int g, input int budget);
    int n;
    n = 0;
    while (!o_valid[g] && n < budget) begin
      tick();
      n++;
    end
    chk("wait_valid", g, int'(o_valid[g]), 1);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    for (int g = 0; g < NI; g++) begin
      chk({name, "_valid"}, g, int'(o_valid[g]), 0);
      chk({name, "_start"}, g, int'(o_start[g]), 0);
      chk({name, "_stop"}, g, int'(o_stop[g]), 0);
      chk({name, "_data"}, g, int'(o_data[g]), 0);
    end
  endtask

  initial begin
    int n;
    logic pv, pr, ps, pe;
    logic [7:0] pd;

    // reset state
    tick(); tick();
    check_all_zero("reset");
    reset = 1'b0;

    // continuous ready, request held high
    request = 1'b1;
    ready = 1'b1;
    chk("pre_request_valid", 0, int'(o_valid[0]), 0);
    tick();
    chk("first_valid", 0, int'(o_valid[0]), 1);
    for (int b = 0; b < 8; b++) begin
      chk("ramp_valid", 0, int'(o_valid[0]), 1);
      chk("ramp_data", 0, int'(o_data[0]), EXP_RAMP[b]);
      chk("ramp_start", 0, int'(o_start[0]), (b == 0) ? 1 : 0);
      chk("ramp_stop", 0, int'(o_stop[0]), (b == 7) ? 1 : 0);
      if (b < 7) tick();
    end
    tick();
    n = 1;
    while (!o_valid[0] && n < 20) begin
      tick();
      n++;
    end
    chk("stop_to_start_cycles", 0, n, 3);
    chk("next_frame_start", 0, int'(o_start[0]), 1);
    repeat (30) tick();
    chk("log_count", 1, (lg_n[1] >= 12) ? 1 : 0, 1);
    chk("log_count", 2, (lg_n[2] >= 12) ? 1 : 0, 1);
    for (int i = 0; i < 12; i++) begin
      chk("frame_diag_d8", 1, lg_data[1][i], EXP_P2_D8[i]);
      chk("frame_diag_d2", 2, lg_data[2][i], EXP_P2_D2[i]);
    end
    for (int i = 0; i < 3; i++) chk("single_pixel_frame", 4, lg_data[4][i], i);

    // backpressure with ready 1,0,0,1; request dropped once the frame starts
    reset_pulse();
    request = 1'b1;
    for (int c = 0; c < 60; c++) begin
      ready = ((c % 4) == 0) || ((c % 4) == 3);
      pv = o_valid[0]; pr = ready; pd = o_data[0]; ps = o_start[0]; pe = o_stop[0];
      tick();
      if (pv && !pr) begin
        chk("hold_valid", 0, int'(o_valid[0]), 1);
        chk("hold_data", 0, int'(o_data[0]), int'(pd));
        chk("hold_start", 0, int'(o_start[0]), int'(ps));
        chk("hold_stop", 0, int'(o_stop[0]), int'(pe));
      end
      if (o_valid[0]) request = 1'b0;
      if (c >= 45) chk("idle_after_request_drop", 0, int'(o_valid[0]), 0);
    end
    chk("bp_transfers", 0, lg_n[0], 8);
    for (int i = 0; i < 8; i++) chk("bp_data", 0, lg_data[0][i], EXP_RAMP[i]);
    request = 1'b1;
    ready = 1'b1;
    chk("rerequest_pre", 0, int'(o_valid[0]), 0);
    tick();
    chk("rerequest_valid", 0, int'(o_valid[0]), 1);
    chk("rerequest_data", 0, int'(o_data[0]), 0);
    chk("rerequest_start", 0, int'(o_start[0]), 1);

    // cancel after the third transfer
    reset_pulse();
    wait_valid(0, 10);
    tick(); tick(); tick();
    cancel = 1'b1;
    tick();
    chk("cancel_valid", 0, int'(o_valid[0]), 0);
    chk("cancel_valid", 3, int'(o_valid[3]), 0);
    cancel = 1'b0;
    tick();
    chk("restart_valid", 3, int'(o_valid[3]), 1);
    chk("restart_data_frame", 3, int'(o_data[3]), 0);
    chk("restart_start", 3, int'(o_start[3]), 1);
    chk("restart_data", 0, int'(o_data[0]), 0);
    chk("cancel_xfer_dropped", 0, lg_n[0], 3);
    cancel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cancel_held_idle", 0, int'(o_valid[0]), 0);
    end
    cancel = 1'b0;

    // asynchronous reset mid-frame, then single-pixel frames
    reset_pulse();
    wait_valid(3, 10);
    tick(); tick();
    #1 reset = 1'b1;
    #1 check_all_zero("async_reset");
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset_valid", 3, int'(o_valid[3]), 1);
    chk("post_reset_data", 3, int'(o_data[3]), 0);
    chk("post_reset_start", 3, int'(o_start[3]), 1);
    for (int i = 0; i < 9; i++) begin
      if (o_valid[4]) begin
        chk("one_pixel_start", 4, int'(o_start[4]), 1);
        chk("one_pixel_stop", 4, int'(o_stop[4]), 1);
      end
      tick();
    end

    // randomized consumer behaviour
    for (int c = 0; c < 3000; c++) begin
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) request = ~request;
      cancel = ($urandom_range(0, 49) == 0);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 499) == 0) #1 reset = 1'b1;
      tick();
    end
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
